// File: rtl/dpr16x4c_ram.sv
// Purpose  : 16x4 distributed dual-port RAM, synchronous write port, combinational read port.
// Latency  : write visible at DO from the writing WCK edge onward; read is zero-cycle.
// Backpress: none; a write is accepted on every WCK edge with WRE=1 and RST=0.
//
// Ports:
//   WCK            write clock, rising edge
//   RST            synchronous active-high reset; reloads every word from INITVAL
//   WRE            write enable, active high
//   WAD3..WAD0     write address (WAD3 = MSB)
//   DI3..DI0       write data    (DI3  = MSB)
//   RAD3..RAD0     read address  (RAD3 = MSB)
//   DO3..DO0       read data     (DO3  = MSB), combinational from RAD and contents
//
// INITVAL holds power-up and reset contents: word n occupies bits [4n+3:4n].
module dpr16x4c_ram #(
    parameter logic [63:0] INITVAL = 64'h0
) (
    input  logic WCK,
    input  logic RST,
    input  logic WRE,
    input  logic WAD3,
    input  logic WAD2,
    input  logic WAD1,
    input  logic WAD0,
    input  logic DI3,
    input  logic DI2,
    input  logic DI1,
    input  logic DI0,
    input  logic RAD3,
    input  logic RAD2,
    input  logic RAD1,
    input  logic RAD0,
    output logic DO3,
    output logic DO2,
    output logic DO1,
    output logic DO0
);

    // Storage kept as one flat vector laid out exactly like INITVAL, so both
    // power-up and reset are a single whole-vector load.
    logic [63:0] r_mem = INITVAL;

    logic [3:0] w_wad;
    logic [3:0] w_rad;
    logic [3:0] w_di;
    logic [3:0] w_do;

    assign w_wad = {WAD3, WAD2, WAD1, WAD0};
    assign w_rad = {RAD3, RAD2, RAD1, RAD0};
    assign w_di  = {DI3, DI2, DI1, DI0};

    // Reset wins over a write on the same edge; the pending write is dropped.
    always_ff @(posedge WCK) begin
        if (RST) begin
            r_mem <= INITVAL;
        end else if (WRE) begin
            r_mem[{w_wad, 2'b00} +: 4] <= w_di;
        end
    end

    // Asynchronous read: a same-address write shows old data until the edge,
    // new data right after it, which gives the one-cycle delay-line behaviour.
    assign w_do = r_mem[{w_rad, 2'b00} +: 4];
    assign {DO3, DO2, DO1, DO0} = w_do;

endmodule

// File: tb/tb_dpr16x4c_ram.sv
module tb_dpr16x4c_ram;

    localparam logic [63:0] INIT_A = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] INIT_B = 64'h0;

    logic       wck = 1'b0;
    logic       rst = 1'b0;
    logic       wre = 1'b0;
    logic [3:0] wad = 4'h0;
    logic [3:0] di  = 4'h0;
    logic [3:0] rad = 4'h0;
    wire  [3:0] do_a;
    wire  [3:0] do_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference contents for both instances: plain arrays of words.
    logic [3:0] m_a [16];
    logic [3:0] m_b [16];

    always #5 wck = ~wck;

    dpr16x4c_ram #(.INITVAL(INIT_A)) u_dut_a (
        .WCK(wck), .RST(rst), .WRE(wre),
        .WAD3(wad[3]), .WAD2(wad[2]), .WAD1(wad[1]), .WAD0(wad[0]),
        .DI3(di[3]), .DI2(di[2]), .DI1(di[1]), .DI0(di[0]),
        .RAD3(rad[3]), .RAD2(rad[2]), .RAD1(rad[1]), .RAD0(rad[0]),
        .DO3(do_a[3]), .DO2(do_a[2]), .DO1(do_a[1]), .DO0(do_a[0])
    );

    dpr16x4c_ram u_dut_b (
        .WCK(wck), .RST(rst), .WRE(wre),
        .WAD3(wad[3]), .WAD2(wad[2]), .WAD1(wad[1]), .WAD0(wad[0]),
        .DI3(di[3]), .DI2(di[2]), .DI1(di[1]), .DI0(di[0]),
        .RAD3(rad[3]), .RAD2(rad[2]), .RAD1(rad[1]), .RAD0(rad[0]),
        .DO3(do_b[3]), .DO2(do_b[2]), .DO1(do_b[1]), .DO0(do_b[0])
    );

    task automatic model_load_init();
        logic [63:0] va;
        logic [63:0] vb;
        va = INIT_A;
        vb = INIT_B;
        for (int n = 0; n < 16; n++) begin
            m_a[n] = 4'((va >> (4 * n)) & 64'hF);
            m_b[n] = 4'((vb >> (4 * n)) & 64'hF);
        end
    endtask

    // Apply the current inputs to the model, then advance one WCK edge and
    // settle 1 time unit past it so outputs are sampled away from the edge.
    task automatic tick();
        if (rst) begin
            model_load_init();
        end else if (wre) begin
            m_a[wad] = di;
            m_b[wad] = di;
        end
        @(posedge wck);
        #1;
    endtask

    task automatic test_powerup();
        for (int n = 0; n < 16; n++) begin
            rad = 4'(n);
            #1;
            n_cmp++;
            if (do_a !== 4'(n)) begin
                n_fail++;
                $display("FAIL powerup_a rad=%0d got=%h want=%h", n, do_a, 4'(n));
            end
            n_cmp++;
            if (do_b !== 4'h0) begin
                n_fail++;
                $display("FAIL powerup_b rad=%0d got=%h want=0", n, do_b);
            end
        end
    endtask

    task automatic test_reset();
        // Scribble over a few words first so the reset has something to undo.
        rst = 1'b0;
        wre = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wad = 4'(n * 5);
            di  = 4'hC;
            tick();
        end
        wre = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 16; n++) begin
            rad = 4'(n);
            #1;
            n_cmp++;
            if (do_a !== 4'(n)) begin
                n_fail++;
                $display("FAIL reset_a rad=%0d got=%h want=%h", n, do_a, 4'(n));
            end
            n_cmp++;
            if (do_b !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_b rad=%0d got=%h want=0", n, do_b);
            end
        end
    endtask

    task automatic test_write_sweep();
        wre = 1'b1;
        for (int n = 0; n < 16; n++) begin
            wad = 4'(n);
            di  = 4'(15 - n);
            tick();
        end
        wre = 1'b0;
        for (int n = 0; n < 16; n++) begin
            rad = 4'(n);
            #1;
            n_cmp++;
            if (do_a !== 4'(15 - n) || do_b !== 4'(15 - n)) begin
                n_fail++;
                $display("FAIL sweep rad=%0d got=%h/%h want=%h", n, do_a, do_b, 4'(15 - n));
            end
        end
    endtask

    task automatic test_we_gating();
        wre = 1'b1; wad = 4'd3; di = 4'hA;
        tick();
        wre = 1'b0; di = 4'h5;
        tick();
        rad = 4'd3;
        #1;
        n_cmp++;
        if (do_a !== 4'hA || do_b !== 4'hA) begin
            n_fail++;
            $display("FAIL we_gating got=%h/%h want=a", do_a, do_b);
        end
    endtask

    task automatic test_same_addr_rdw();
        wre = 1'b1; wad = 4'd7; di = 4'h1;
        tick();
        rad = 4'd7; di = 4'h6;
        #1;
        n_cmp++;
        if (do_a !== 4'h1 || do_b !== 4'h1) begin
            n_fail++;
            $display("FAIL rdw_before got=%h/%h want=1", do_a, do_b);
        end
        tick();
        n_cmp++;
        if (do_a !== 4'h6 || do_b !== 4'h6) begin
            n_fail++;
            $display("FAIL rdw_after got=%h/%h want=6", do_a, do_b);
        end
        wre = 1'b0;
    endtask

    task automatic test_delay_line();
        logic [4:0] pat;
        pat = 5'b11001; // LSB first: 1,0,0,1,1
        wad = 4'd0; rad = 4'd0; wre = 1'b1;
        for (int k = 0; k < 5; k++) begin
            di = {3'b000, pat[k]};
            tick();
            // DO0 now shows the bit presented one cycle earlier
            n_cmp++;
            if (do_a[0] !== pat[k] || do_b[0] !== pat[k]) begin
                n_fail++;
                $display("FAIL delay_line k=%0d got=%b/%b want=%b", k, do_a[0], do_b[0], pat[k]);
            end
        end
        wre = 1'b0;
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; wre = 1'b1; wad = 4'd2; di = 4'hF; rad = 4'd2;
        tick();
        n_cmp++;
        if (do_b !== 4'h0 || do_a !== 4'h2) begin
            n_fail++;
            $display("FAIL rst_priority got=%h/%h want=2/0", do_a, do_b);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (do_a !== 4'hF || do_b !== 4'hF) begin
            n_fail++;
            $display("FAIL rst_resume got=%h/%h want=f", do_a, do_b);
        end
        wre = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            wre = $urandom_range(0, 1) == 1;
            wad = 4'($urandom_range(0, 15));
            di  = 4'($urandom_range(0, 15));
            rad = ($urandom_range(0, 3) == 0) ? wad : 4'($urandom_range(0, 15));
            #1;
            // Combinational read before the edge reflects current contents
            n_cmp++;
            if (do_a !== m_a[rad] || do_b !== m_b[rad]) begin
                n_fail++;
                $display("FAIL rand_pre c=%0d rad=%0d got=%h/%h want=%h/%h",
                         c, rad, do_a, do_b, m_a[rad], m_b[rad]);
            end
            tick();
            n_cmp++;
            if (do_a !== m_a[rad] || do_b !== m_b[rad]) begin
                n_fail++;
                $display("FAIL rand_post c=%0d rad=%0d got=%h/%h want=%h/%h",
                         c, rad, do_a, do_b, m_a[rad], m_b[rad]);
            end
        end
        rst = 1'b0;
        wre = 1'b0;
    endtask

    initial begin
        model_load_init();
        test_powerup();
        test_reset();
        test_write_sweep();
        test_we_gating();
        test_same_addr_rdw();
        test_delay_line();
        test_reset_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
